axi_rd_master: RTL and testbench
================================

AXI_RD_MASTER -- requirements
Module: axi_rd_master

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum beats per burst (AXI3 HP-port limit).
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 START_REG  in  1  issue request; sampled only in IDLE_ST.
REQ-005 ADDR_REG  in  32  byte address of burst.
REQ-006 LENGTH_REG  in  32  beats in burst; valid range 1..MAX_LEN.
REQ-007 IDLE_REG  out  1  high only while in IDLE_ST.
REQ-008 CLR_REG  in  1  synchronous clear of statistics and error flags.
REQ-009 ERR_REG  out  3  sticky flags: [0] bad length/4KB cross, [1] RRESP!=OKAY, [2] RLAST mismatch.
REQ-010 BEATS_REG  out  32  total R beats accepted since reset/clear.
REQ-011 CSUM_REG  out  64  XOR of all accepted RDATA since reset/clear.
REQ-012 m_axi_araddr/arlen/arsize/arburst  out  32/4/3/2  AR payload.
REQ-013 m_axi_arvalid  out 1; m_axi_arready  in 1  AR handshake.
REQ-014 m_axi_rdata/rresp/rlast/rvalid  in  64/2/1/1; m_axi_rready  out 1  R channel.

Function
REQ-015 FSM states SHALL be IDLE_ST, CHECK_ST, ADDR_ST, DATA_ST, DONE_ST.
REQ-016 IDLE_ST: START_REG=1 -> latch ADDR_REG (bits [2:0] forced 0) and LENGTH_REG; go CHECK_ST.
REQ-017 CHECK_ST: length 0, length >MAX_LEN, or (addr[11:0] + 8*len) >4096 -> set ERR_REG[0], go DONE_ST, no AR issued; else ADDR_ST.
REQ-018 ADDR_ST: arvalid=1, araddr=latched addr, arlen=len-1, arsize=3'b011, arburst=2'b01; payload stable while arvalid high.
REQ-019 AR handshake (arvalid & arready) -> arvalid low next cycle, go DATA_ST; arvalid never drops before handshake.
REQ-020 DATA_ST: rready=1; each rvalid&rready beat increments beat index, BEATS_REG, and XORs rdata into CSUM_REG.
REQ-021 RRESP != 2'b00 on any beat -> set ERR_REG[1]; beat still counted.
REQ-022 Beat with rlast=1 -> go DONE_ST; if beat index != len set ERR_REG[2].
REQ-023 Beat index reaching len without rlast -> set ERR_REG[2]; keep accepting until rlast.
REQ-024 DONE_ST: one cycle, then IDLE_ST; START_REG held high re-issues a new burst (level-sensitive, one burst per IDLE_ST visit).
REQ-025 rready=0 and arvalid=0 outside DATA_ST and ADDR_ST respectively.
REQ-026 BEATS_REG wraps 0xFFFFFFFF -> 0 silently.
REQ-027 CLR_REG=1 zeroes BEATS_REG, CSUM_REG, ERR_REG next cycle; same-cycle beat is discarded from stats; FSM unaffected.
REQ-028 Minimum latency START_REG sampled -> arvalid high: 2 cycles.

Reset
REQ-029 rstn low -> IDLE_ST, IDLE_REG=1, arvalid=0, rready=0, araddr/arlen=0, BEATS_REG=0, CSUM_REG=0, ERR_REG=0, immediately and asynchronously.
REQ-030 rstn asserted mid-burst SHALL abandon the transaction; no outstanding-beat tracking across reset.
REQ-031 Deassertion SHALL be synchronous to clk; first START_REG honoured on the cycle after release.

Verification
REQ-032 ADDR=0x1000_0000, LEN=8, arready=1, 8 OKAY beats data=1..8, rlast on 8th -> arlen=7, arsize=3, BEATS=8, CSUM=0x08, ERR=0, IDLE high after DONE_ST.
REQ-033 arready held low 5 cycles -> arvalid and payload stable all 5 cycles; single handshake; burst completes normally.
REQ-034 LEN=0, then LEN=17, then ADDR=0x0FC8 LEN=8 (crosses 4KB) -> no arvalid each time, ERR[0]=1, IDLE returns within 3 cycles.
REQ-035 LEN=4, rlast on beat 3 -> ERR[2]=1, BEATS=3; rresp=SLVERR on beat 2 -> ERR[1]=1.
REQ-036 START held high for 1000 cycles, LEN=8, slave always ready -> back-to-back bursts, BEATS multiple of 8, one AR per burst; CLR pulse -> BEATS=0, CSUM=0, ERR=0.
REQ-037 rstn pulsed low during DATA_ST beat 3 -> all outputs at reset values same cycle; new burst after release completes correctly.

Source files
------------

// File: rtl/axi_rd_master.sv
// AXI3 single-outstanding INCR read master: validates a burst request, issues one AR,
// consumes the R beats and keeps a beat count, an XOR checksum and sticky error flags.
module axi_rd_master #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        START_REG,
  input  logic [31:0] ADDR_REG,
  input  logic [31:0] LENGTH_REG,
  output logic        IDLE_REG,
  input  logic        CLR_REG,
  output logic [2:0]  ERR_REG,
  output logic [31:0] BEATS_REG,
  output logic [63:0] CSUM_REG,
  output logic [31:0] m_axi_araddr,
  output logic [3:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  typedef enum logic [2:0] {IDLE_ST, CHECK_ST, ADDR_ST, DATA_ST, DONE_ST} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [3:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        idle_q, idle_d;
  logic [2:0]  err_q, err_d;
  logic [31:0] beats_q, beats_d;
  logic [63:0] csum_q, csum_d;

  logic [35:0] end_byte;
  logic [31:0] idx_inc;
  logic        bad_req;
  logic        beat;

  // Wide sum so a huge length cannot wrap back under the 4KB limit.
  assign end_byte = {24'd0, addr_q[11:0]} + {1'b0, len_q, 3'b000};
  assign bad_req  = (len_q == 32'd0) || (len_q > 32'(MAX_LEN)) || (end_byte > 36'd4096);
  assign beat     = m_axi_rvalid && rready_q;
  assign idx_inc  = idx_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    beats_d   = beats_q;
    csum_d    = csum_q;
    case (state_q)
      IDLE_ST: begin
        if (START_REG) begin
          addr_d  = ADDR_REG & 32'hFFFF_FFF8;
          len_d   = LENGTH_REG;
          idx_d   = 32'd0;
          state_d = CHECK_ST;
        end
      end
      CHECK_ST: begin
        if (bad_req) begin
          err_d[0] = 1'b1;
          state_d  = DONE_ST;
        end else begin
          arlen_d   = 4'(len_q - 32'd1);
          arvalid_d = 1'b1;
          state_d   = ADDR_ST;
        end
      end
      ADDR_ST: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA_ST;
        end
      end
      DATA_ST: begin
        if (beat) begin
          idx_d   = idx_inc;
          beats_d = beats_q + 32'd1;
          csum_d  = csum_q ^ m_axi_rdata;
          if (m_axi_rresp != 2'b00) err_d[1] = 1'b1;
          if (m_axi_rlast) begin
            if (idx_inc != len_q) err_d[2] = 1'b1;
            rready_d = 1'b0;
            state_d  = DONE_ST;
          end else if (idx_inc == len_q) begin
            err_d[2] = 1'b1;
          end
        end
      end
      DONE_ST: state_d = IDLE_ST;
      default: state_d = IDLE_ST;
    endcase
    // Clear wins over anything the same cycle would have recorded.
    if (CLR_REG) begin
      err_d   = 3'd0;
      beats_d = 32'd0;
      csum_d  = 64'd0;
    end
  end

  assign idle_d = (state_d == IDLE_ST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE_ST;
      addr_q    <= 32'd0;
      len_q     <= 32'd0;
      idx_q     <= 32'd0;
      arlen_q   <= 4'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      idle_q    <= 1'b1;
      err_q     <= 3'd0;
      beats_q   <= 32'd0;
      csum_q    <= 64'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      beats_q   <= beats_d;
      csum_q    <= csum_d;
    end
  end

  assign IDLE_REG      = idle_q;
  assign ERR_REG       = err_q;
  assign BEATS_REG     = beats_q;
  assign CSUM_REG      = csum_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_rd_master.sv
// Bench for axi_rd_master: a transaction-level slave/model predicts every output each cycle
// from the burst rules, plus literal checks for the directed scenarios.
module tb_axi_rd_master;
  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        START_REG, CLR_REG;
  logic [31:0] ADDR_REG, LENGTH_REG;
  logic        IDLE_REG;
  logic [2:0]  ERR_REG;
  logic [31:0] BEATS_REG;
  logic [63:0] CSUM_REG;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_rd_master #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rstn(rstn), .START_REG(START_REG), .ADDR_REG(ADDR_REG),
    .LENGTH_REG(LENGTH_REG), .IDLE_REG(IDLE_REG), .CLR_REG(CLR_REG), .ERR_REG(ERR_REG),
    .BEATS_REG(BEATS_REG), .CSUM_REG(CSUM_REG), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // Expected outputs, maintained by the transaction model
  logic        exp_idle, exp_arvalid, exp_rready;
  logic [31:0] exp_araddr, exp_beats;
  logic [3:0]  exp_arlen;
  logic [2:0]  exp_err;
  logic [63:0] exp_csum;

  int n_cmp = 0, n_bad = 0;
  int n_ar_exp = 0, n_ar_seen = 0, cyc = 0;
  logic [31:0] cap_araddr;
  logic [3:0]  cap_arlen;
  logic [2:0]  cap_arsize;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_idle = 1'b1; exp_arvalid = 1'b0; exp_rready = 1'b0;
    exp_araddr = 32'd0; exp_arlen = 4'd0; exp_err = 3'd0;
    exp_beats = 32'd0; exp_csum = 64'd0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (m_axi_arvalid && m_axi_arready) begin
      n_ar_seen++;
      cap_araddr = m_axi_araddr;
      cap_arlen  = m_axi_arlen;
      cap_arsize = m_axi_arsize;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("idle", IDLE_REG, exp_idle);
    check("arvalid", m_axi_arvalid, exp_arvalid);
    check("rready", m_axi_rready, exp_rready);
    check("err", ERR_REG, exp_err);
    check("beats", BEATS_REG, exp_beats);
    check("csum", CSUM_REG, exp_csum);
    if (exp_arvalid) begin
      check("araddr", m_axi_araddr, exp_araddr);
      check("arlen", m_axi_arlen, exp_arlen);
      check("arsize", m_axi_arsize, 3'b011);
      check("arburst", m_axi_arburst, 2'b01);
    end
  end

  task automatic clr_pulse();
    CLR_REG = 1'b1;
    tick();
    exp_beats = 32'd0; exp_csum = 64'd0; exp_err = 3'd0;
    CLR_REG = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [31:0] len, input int rlast_at,
                           input int err_beat, input int ar_delay, input int clr_beat,
                           input int rst_beat, input bit seq_data, input int gap_max,
                           input bit hold);
    logic [31:0] aligned;
    longint      off;
    bit          ok, last;
    logic [63:0] data;
    logic [1:0]  resp;
    aligned = addr & 32'hFFFF_FFF8;
    off = longint'(aligned & 32'h0000_0FFF);
    ok = (len != 0) && (len <= MAX_LEN) && (off + 8 * longint'(len) <= 4096);
    START_REG = 1'b1; ADDR_REG = addr; LENGTH_REG = len;
    tick();
    if (!hold) START_REG = 1'b0;
    exp_idle = 1'b0;
    tick();
    if (!ok) begin
      exp_err[0] = 1'b1;
      tick();
      exp_idle = 1'b1;
      $display("burst addr=%h len=%0d rejected", addr, len);
      return;
    end
    exp_arvalid = 1'b1; exp_araddr = aligned; exp_arlen = 4'(len - 1);
    for (int k = 0; k <= ar_delay; k++) begin
      m_axi_arready = (k == ar_delay);
      tick();
    end
    m_axi_arready = 1'b0;
    exp_arvalid = 1'b0; exp_rready = 1'b1; n_ar_exp++;
    for (int i = 1; i <= rlast_at; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        m_axi_rdata = {$urandom, $urandom};
        tick();
      end
      if (i == rst_beat) begin
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        check("rst_idle", IDLE_REG, 1'b1);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_araddr", m_axi_araddr, 32'd0);
        check("rst_arlen", m_axi_arlen, 4'd0);
        check("rst_beats", BEATS_REG, 32'd0);
        check("rst_csum", CSUM_REG, 64'd0);
        check("rst_err", ERR_REG, 3'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        $display("burst addr=%h len=%0d abandoned by reset at beat %0d", addr, len, i);
        return;
      end
      data = seq_data ? 64'(i) : {$urandom, $urandom};
      resp = (i == err_beat) ? 2'b10 : 2'b00;
      last = (i == rlast_at);
      m_axi_rdata = data; m_axi_rresp = resp; m_axi_rlast = last; m_axi_rvalid = 1'b1;
      CLR_REG = (i == clr_beat);
      tick();
      if (i == clr_beat) begin
        exp_beats = 32'd0; exp_csum = 64'd0; exp_err = 3'd0;
      end else begin
        exp_beats++;
        exp_csum ^= data;
        if (resp != 2'b00) exp_err[1] = 1'b1;
        if ((last && i != len) || (!last && i == len)) exp_err[2] = 1'b1;
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; CLR_REG = 1'b0;
    end
    exp_rready = 1'b0;
    tick();
    exp_idle = 1'b1;
    $display("burst addr=%h len=%0d beats=%0d done err=%b", addr, len, rlast_at, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb, ar0, start_cyc, len, rl, clrb;
    logic [31:0] addr;
    rstn = 1'b0; START_REG = 1'b0; CLR_REG = 1'b0; ADDR_REG = 32'd0; LENGTH_REG = 32'd0;
    m_axi_arready = 1'b0; m_axi_rdata = 64'd0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    model_reset();
    tick(); tick();
    check("init_idle", IDLE_REG, 1'b1);
    check("init_arvalid", m_axi_arvalid, 1'b0);
    check("init_beats", BEATS_REG, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Basic 8-beat burst, data 1..8
    run_burst(32'h1000_0000, 8, 8, 0, 0, 0, 0, 1'b1, 1, 1'b0);
    check("b1_araddr", cap_araddr, 32'h1000_0000);
    check("b1_arlen", cap_arlen, 4'd7);
    check("b1_arsize", cap_arsize, 3'd3);
    check("b1_beats", BEATS_REG, 32'd8);
    check("b1_csum", CSUM_REG, 64'h8);
    check("b1_err", ERR_REG, 3'd0);
    check("b1_idle", IDLE_REG, 1'b1);

    // Slave stalls AR for 5 cycles
    ar0 = n_ar_seen;
    run_burst(32'h2000_0044, 4, 4, 0, 5, 0, 0, 1'b0, 2, 1'b0);
    check("stall_one_ar", n_ar_seen - ar0, 1);
    check("stall_araddr", cap_araddr, 32'h2000_0040);

    // Rejected requests
    run_burst(32'h0000_0100, 0, 1, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    check("len0_err0", ERR_REG[0], 1'b1);
    run_burst(32'h0000_0100, 17, 1, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    check("len17_err0", ERR_REG[0], 1'b1);
    run_burst(32'h0000_0FC8, 8, 8, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    check("x4k_err0", ERR_REG[0], 1'b1);
    check("rejects_no_ar", n_ar_seen, 2);

    // Early rlast plus SLVERR
    clr_pulse();
    run_burst(32'h3000_0000, 4, 3, 2, 1, 0, 0, 1'b0, 1, 1'b0);
    check("early_err", ERR_REG, 3'b110);
    check("early_beats", BEATS_REG, 32'd3);

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      if ($urandom_range(0, 2) == 0) addr[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      len = $urandom_range(0, 18);
      rl = len;
      if ($urandom_range(0, 5) == 0 && len > 1) rl = len - 1;
      else if ($urandom_range(0, 5) == 0) rl = len + 1;
      clrb = ($urandom_range(0, 7) == 0 && rl > 0) ? $urandom_range(1, rl) : 0;
      run_burst(addr, len, rl, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 16) : 0,
                $urandom_range(0, 3), clrb, 0, 1'b0, 2, 1'b0);
    end

    // START held high: back-to-back bursts
    clr_pulse();
    ar0 = n_ar_seen; nb = 0; start_cyc = cyc;
    while (cyc - start_cyc < 1000) begin
      run_burst(32'h4000_0000 + 32'(nb * 64), 8, 8, 0, 0, 0, 0, 1'b0, 0, 1'b1);
      nb++;
    end
    run_burst(32'h4000_0000 + 32'(nb * 64), 8, 8, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    nb++;
    check("hold_ar_per_burst", n_ar_seen - ar0, nb);
    check("hold_beats", BEATS_REG, 32'(8 * nb));
    clr_pulse();
    check("clr_beats", BEATS_REG, 32'd0);
    check("clr_csum", CSUM_REG, 64'd0);
    check("clr_err", ERR_REG, 3'd0);

    // Reset during beat 3, then a clean burst
    run_burst(32'h5000_0000, 8, 8, 0, 0, 0, 3, 1'b1, 0, 1'b0);
    run_burst(32'h5000_0000, 8, 8, 0, 0, 0, 0, 1'b1, 1, 1'b0);
    check("post_rst_beats", BEATS_REG, 32'd8);
    check("post_rst_csum", CSUM_REG, 64'h8);
    check("total_ar", n_ar_seen, n_ar_exp);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
